// File: rtl/shift_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification helpers
// for the multi-cycle shift/rotate sequencer and its single-bit step.
package shift_sequencer_pkg;

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_ROL);
    endfunction

    // Shifts saturate on large amounts; rotates wrap modulo the width instead.
    function automatic logic op_is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHRA) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step, purely combinational.
// Latency: 0 cycles. Backpressure: none (no handshake).
// Illegal opcodes pass the operand through unchanged.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (op)
            OP_SHR:  data_out = {1'b0, data_in[WIDTH-1:1]};
            OP_SHRA: data_out = {data_in[WIDTH-1], data_in[WIDTH-1:1]};
            OP_SHL:  data_out = {data_in[WIDTH-2:0], 1'b0};
            OP_ROR:  data_out = {data_in[0], data_in[WIDTH-1:1]};
            OP_ROL:  data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shift/rotate unit: one bit per clock, result reported with a done pulse.
// Latency: n+1 cycles from accepted start (n = amount mod WIDTH, 1 when saturated/illegal).
// Backpressure: start is only sampled while idle; requests during busy are dropped.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [31:0]       amount,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WIDTH-1:0]  result
);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  work, work_nxt;
    logic [WIDTH-1:0]  step_out;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [2:0]        op_q, op_nxt;
    logic              ill_q, ill_nxt;
    logic [WIDTH-1:0]  result_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic              amount_sat;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op       (op_q),
        .data_in  (work),
        .data_out (step_out)
    );

    // Any bit above the counter field means the shift moves out every bit.
    assign amount_sat = |amount[31:CNT_W];
    assign busy       = (state == ST_RUN);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= ST_IDLE;
            work   <= '0;
            cnt    <= '0;
            op_q   <= OP_SHR;
            ill_q  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            work   <= work_nxt;
            cnt    <= cnt_nxt;
            op_q   <= op_nxt;
            ill_q  <= ill_nxt;
            result <= result_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        work_nxt   = work;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        ill_nxt    = ill_q;
        result_nxt = result;
        done_nxt   = 1'b0;
        err_nxt    = err;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    op_nxt    = op;
                    err_nxt   = 1'b0;
                    if (!op_is_legal(op)) begin
                        work_nxt = data_in;
                        cnt_nxt  = '0;
                        ill_nxt  = 1'b1;
                    end else if (op_is_shift(op) && amount_sat) begin
                        // Preload the fully-shifted value and finish in one cycle.
                        work_nxt = (op == OP_SHRA) ? {WIDTH{data_in[WIDTH-1]}} : '0;
                        cnt_nxt  = '0;
                        ill_nxt  = 1'b0;
                    end else begin
                        work_nxt = data_in;
                        cnt_nxt  = amount[CNT_W-1:0];
                        ill_nxt  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (cnt != '0) begin
                    work_nxt = step_out;
                    cnt_nxt  = cnt - CNT_W'(1);
                end else begin
                    result_nxt = work;
                    done_nxt   = 1'b1;
                    err_nxt    = ill_q;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, latencies and flags.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [31:0] amount;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    shift_sequencer #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Counts negedges after acceptance until done; lat ends as n+1.
    task automatic wait_done(inout int lat, inout int bsy);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bsy++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] d,
                       input logic [31:0] a, input logic [31:0] exp_res,
                       input int exp_lat, input logic exp_err);
        int lat;
        int bsy;
        @(negedge clk);
        op = o; data_in = d; amount = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bsy = busy ? 1 : 0;
        wait_done(lat, bsy);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, bsy, exp_lat);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int bsy;
        int done_cnt;

        clr = 1'b1; start = 1'b0; op = 3'd0; data_in = '0; amount = '0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        run("ror1",     3'd3, 32'h0000_0001, 32'd1,     32'h8000_0000, 2,  1'b0);
        run("ror5",     3'd3, 32'h0040_0000, 32'd5,     32'h0002_0000, 6,  1'b0);
        run("ror33",    3'd3, 32'h0000_0001, 32'd33,    32'h8000_0000, 2,  1'b0);
        run("shra4",    3'd1, 32'h8000_0000, 32'd4,     32'hF800_0000, 5,  1'b0);
        run("shr4",     3'd0, 32'h8000_0000, 32'd4,     32'h0800_0000, 5,  1'b0);
        run("shl_sat",  3'd2, 32'hFFFF_FFFF, 32'd40,    32'h0000_0000, 1,  1'b0);
        run("shra_sat", 3'd1, 32'h8000_0010, 32'h100,   32'hFFFF_FFFF, 1,  1'b0);
        run("shra_pos", 3'd1, 32'h7FFF_FFFF, 32'd64,    32'h0000_0000, 1,  1'b0);
        run("shr0",     3'd0, 32'hA5A5_A5A5, 32'd0,     32'hA5A5_A5A5, 1,  1'b0);
        run("rol32",    3'd4, 32'h1234_5678, 32'd32,    32'h1234_5678, 1,  1'b0);
        run("shl31",    3'd2, 32'h0000_0003, 32'd31,    32'h8000_0000, 32, 1'b0);
        run("ill6",     3'd6, 32'hDEAD_BEEF, 32'd7,     32'hDEAD_BEEF, 1,  1'b1);
        chk("err_held", {31'd0, err}, 32'd1);
        run("err_clr",  3'd4, 32'h0000_0001, 32'd4,     32'h0000_0010, 5,  1'b0);

        // ROL by 31 with a spurious start and changed operands mid-run.
        @(negedge clk);
        op = 3'd4; data_in = 32'h8000_0001; amount = 32'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bsy = 1;
        repeat (3) begin
            @(negedge clk);
            lat++;
            bsy++;
        end
        start = 1'b1; op = 3'd0; data_in = 32'h1234_5678; amount = 32'd2;
        @(negedge clk);
        lat++;
        bsy++;
        start = 1'b0;
        wait_done(lat, bsy);
        chk("rol31_res", result, 32'hC000_0000);
        chk("rol31_lat", lat, 32);
        @(negedge clk);
        chk("rol31_idle", {31'd0, busy}, 32'd0);

        // Asynchronous clear in the middle of ROR by 20.
        @(negedge clk);
        op = 3'd3; data_in = 32'h0000_00F0; amount = 32'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_done", {31'd0, done}, 32'd0);
        chk("clr_result", result, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        done_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("clr_no_done", done_cnt, 0);
        run("post_clr", 3'd3, 32'h0000_0001, 32'd1, 32'h8000_0000, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
